fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 25 ++
 rtl/fetch_unit.sv | 164 ++++++++++++++++
 tb/tb_fetch_unit.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch unit (master)
// and the instruction SRAM controller (slave).
interface fetch_unit_if;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    modport master (
        output inst_sram_req,
        output inst_sram_addr,
        input  inst_sram_addr_ok,
        input  inst_sram_data_ok,
        input  inst_sram_rdata
    );

    modport slave (
        input  inst_sram_req,
        input  inst_sram_addr,
        output inst_sram_addr_ok,
        output inst_sram_data_ok,
        output inst_sram_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one outstanding instruction-memory request at a
// time, buffers the returned word and hands it to ID, honouring delayed-branch redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          stall_i,
    input  logic [32:0]         br_bus_i,
    fetch_unit_if.master        inst_sram,
    output logic [32:0]         if_to_id_bus_o,
    output logic [31:0]         if_inst_o,
    output logic                stallreq_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_FULL = 2'd3
    } state_e;

    state_e      state_q,       state_d;
    logic        req_q,         req_d;
    logic [31:0] addr_q,        addr_d;
    logic [31:0] fetch_pc_q,    fetch_pc_d;
    logic        pc_fresh_q,    pc_fresh_d;
    logic        buf_valid_q,   buf_valid_d;
    logic [31:0] buf_pc_q,      buf_pc_d;
    logic [31:0] inst_q,        inst_d;
    logic        redir_valid_q, redir_valid_d;
    logic [31:0] redir_addr_q,  redir_addr_d;

    logic        br_e_s;
    logic [31:0] br_addr_s;
    logic        handoff_s;
    logic        launch_s;
    logic [31:0] launch_pc_s;
    logic        stall_unused_s;

    assign br_e_s         = br_bus_i[32];
    assign br_addr_s      = br_bus_i[31:0];
    assign stall_unused_s = ^stall_i[5:2];

    // The buffered word leaves on any FULL edge not held by stall[1];
    // a new fetch may launch from IDLE or on that same handoff edge.
    assign handoff_s   = (state_q == S_FULL) && !stall_i[1];
    assign launch_s    = ((state_q == S_IDLE) || handoff_s) && !stall_i[0];
    // pc_fresh marks a fetch_pc that has never been issued (the reset vector).
    assign launch_pc_s = redir_valid_q ? redir_addr_q :
                         (pc_fresh_q ? fetch_pc_q : (fetch_pc_q + 32'd4));

    // Next-state logic for the fetch FSM, buffer and redirect latch.
    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        addr_d        = addr_q;
        fetch_pc_d    = fetch_pc_q;
        pc_fresh_d    = pc_fresh_q;
        buf_valid_d   = buf_valid_q;
        buf_pc_d      = buf_pc_q;
        inst_d        = inst_q;
        redir_valid_d = redir_valid_q;
        redir_addr_d  = redir_addr_q;

        case (state_q)
            S_IDLE: begin
                if (!stall_i[0]) begin
                    state_d = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (inst_sram.inst_sram_addr_ok) begin
                    state_d = S_WAIT;
                    req_d   = 1'b0;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (inst_sram.inst_sram_data_ok) begin
                    state_d     = S_FULL;
                    buf_valid_d = 1'b1;
                    buf_pc_d    = fetch_pc_q;
                    inst_d      = inst_sram.inst_sram_rdata;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_FULL: begin
                if (!stall_i[1]) begin
                    buf_valid_d = 1'b0;
                    if (stall_i[0]) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_REQ;
                    end
                end else begin
                    state_d = S_FULL;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase

        // The address is only ever rewritten here, so a pending redirect can
        // never disturb a request already on the bus.
        if (launch_s) begin
            req_d         = 1'b1;
            addr_d        = launch_pc_s;
            fetch_pc_d    = launch_pc_s;
            pc_fresh_d    = 1'b0;
            redir_valid_d = 1'b0;
        end else begin
            req_d = req_d;
        end

        // A branch seen on the launch edge re-arms the redirect for the next launch.
        if (br_e_s) begin
            redir_valid_d = 1'b1;
            redir_addr_d  = br_addr_s;
        end else begin
            redir_addr_d = redir_addr_d;
        end
    end

    // State registers with synchronous reset; reset abandons any outstanding request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            req_q         <= 1'b0;
            addr_q        <= RESET_PC;
            fetch_pc_q    <= RESET_PC;
            pc_fresh_q    <= 1'b1;
            buf_valid_q   <= 1'b0;
            buf_pc_q      <= 32'd0;
            inst_q        <= 32'd0;
            redir_valid_q <= 1'b0;
            redir_addr_q  <= 32'd0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            addr_q        <= addr_d;
            fetch_pc_q    <= fetch_pc_d;
            pc_fresh_q    <= pc_fresh_d;
            buf_valid_q   <= buf_valid_d;
            buf_pc_q      <= buf_pc_d;
            inst_q        <= inst_d;
            redir_valid_q <= redir_valid_d;
            redir_addr_q  <= redir_addr_d;
        end
    end

    assign inst_sram.inst_sram_req  = req_q;
    assign inst_sram.inst_sram_addr = addr_q;
    assign if_to_id_bus_o           = {buf_valid_q, buf_pc_q};
    assign if_inst_o                = inst_q;
    assign stallreq_o               = ~rst & ~buf_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scoreboard bench for fetch_unit: a behavioural instruction memory with
// programmable handshake delays, and a handoff monitor popping expected pcs.
module tb_fetch_unit;
    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic [32:0] br_bus;
    logic [32:0] if_to_id_bus;
    logic [31:0] if_inst;
    logic        stallreq;

    fetch_unit_if bus();

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall),
        .br_bus_i       (br_bus),
        .inst_sram      (bus),
        .if_to_id_bus_o (if_to_id_bus),
        .if_inst_o      (if_inst),
        .stallreq_o     (stallreq)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int a_dly    = 0;
    int d_dly    = 0;
    bit inject   = 1'b0;

    logic [31:0] exp_pc[$];
    logic [31:0] req_log[$];
    int          hand_cyc[$];

    wire         ce     = if_to_id_bus[32];
    wire  [31:0] bus_pc = if_to_id_bus[31:0];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5A5_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Behavioural instruction memory: addr_ok after a_dly idle cycles, data_ok d_dly later.
    int          m_ph  = 0;
    int          m_cnt = 0;
    logic [31:0] m_lat = 32'd0;
    initial begin
        bus.inst_sram_addr_ok = 1'b0;
        bus.inst_sram_data_ok = 1'b0;
        bus.inst_sram_rdata   = 32'd0;
    end
    always @(negedge clk) begin
        bus.inst_sram_addr_ok = 1'b0;
        bus.inst_sram_data_ok = 1'b0;
        if (rst) begin
            m_ph  = 0;
            m_cnt = 0;
            bus.inst_sram_data_ok = inject;
            bus.inst_sram_rdata   = 32'hDEAD_BEEF;
        end else if (m_ph == 0) begin
            if (bus.inst_sram_req) begin
                if (m_cnt >= a_dly) begin
                    bus.inst_sram_addr_ok = 1'b1;
                    m_lat = bus.inst_sram_addr;
                    m_ph  = 1;
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
        end else begin
            if (m_cnt >= d_dly) begin
                bus.inst_sram_data_ok = 1'b1;
                bus.inst_sram_rdata   = mem_word(m_lat);
                m_ph  = 0;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
    end

    // Handoff monitor, request logger, address-stability and stallreq checks.
    logic        prev_req  = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    always @(negedge clk) begin
        chk("stallreq", 64'(stallreq), rst ? 64'd0 : 64'(!ce));
        if (!rst) begin
            if (bus.inst_sram_req && prev_req)
                chk("addr_stable", 64'(bus.inst_sram_addr), 64'(prev_addr));
            if (bus.inst_sram_req && !prev_req)
                req_log.push_back(bus.inst_sram_addr);
            if (ce && !stall[1]) begin
                hand_cyc.push_back(cyc);
                chk("handoff_expected", 64'(exp_pc.size() > 0), 64'd1);
                if (exp_pc.size() > 0) begin
                    logic [31:0] e;
                    e = exp_pc.pop_front();
                    chk("handoff_pc", 64'(bus_pc), 64'(e));
                    chk("handoff_inst", 64'(if_inst), 64'(mem_word(e)));
                end
            end
        end
        prev_req  = bus.inst_sram_req && !rst;
        prev_addr = bus.inst_sram_addr;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_pc(input logic [31:0] pc, input int budget, input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            tick();
            if (ce && bus_pc == pc) found = 1'b1;
        end
        chk(tag, 64'(found), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int c0;
        rst    = 1'b1;
        stall  = 6'b0;
        br_bus = 33'd0;
        tick(3);

        // Reset state
        chk("rst_req",      64'(bus.inst_sram_req),  64'd0);
        chk("rst_addr",     64'(bus.inst_sram_addr), 64'hBFC0_0000);
        chk("rst_bus",      64'(if_to_id_bus),       64'd0);
        chk("rst_inst",     64'(if_inst),            64'd0);
        chk("rst_stallreq", 64'(stallreq),           64'd0);

        // First fetch with late addr_ok/data_ok, then a full-rate stream
        a_dly = 1;
        d_dly = 1;
        exp_pc.push_back(32'hBFC0_0000);
        exp_pc.push_back(32'hBFC0_0004);
        exp_pc.push_back(32'hBFC0_0008);
        exp_pc.push_back(32'hBFC0_000C);
        rst = 1'b0;
        tick();
        chk("first_req",  64'(bus.inst_sram_req),  64'd1);
        chk("first_addr", 64'(bus.inst_sram_addr), 64'hBFC0_0000);
        wait_pc(32'hBFC0_0000, 10, "first_ce");
        chk("first_inst",     64'(if_inst),  64'(mem_word(32'hBFC0_0000)));
        chk("first_stallreq", 64'(stallreq), 64'd0);
        a_dly = 0;
        d_dly = 0;
        wait_pc(32'hBFC0_000C, 20, "stream_ce");
        chk("spacing_cnt", 64'(hand_cyc.size()), 64'd3);
        if (hand_cyc.size() == 3) begin
            chk("spacing_0_4", 64'(hand_cyc[1] - hand_cyc[0]), 64'd3);
            chk("spacing_4_8", 64'(hand_cyc[2] - hand_cyc[1]), 64'd3);
        end

        // Hold the buffer with stall[1] for five cycles, keep stall[0] to park in IDLE
        stall = 6'b000011;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_ce",   64'(ce),              64'd1);
            chk("hold_pc",   64'(bus_pc),          64'hBFC0_000C);
            chk("hold_inst", 64'(if_inst),         64'(mem_word(32'hBFC0_000C)));
            chk("hold_req",  64'(bus.inst_sram_req), 64'd0);
        end
        stall = 6'b000001;
        c0 = cyc;
        tick();
        chk("release_handoff_cyc", 64'(hand_cyc[hand_cyc.size() - 1]), 64'(c0));
        chk("release_ce",  64'(ce),                 64'd0);
        tick();
        chk("idle_req",    64'(bus.inst_sram_req),  64'd0);

        // Slow addr_ok with a branch during the wait
        a_dly = 4;
        exp_pc.push_back(32'hBFC0_0010);
        exp_pc.push_back(32'h8000_0200);
        stall = 6'b0;
        tick();
        chk("slow_req",  64'(bus.inst_sram_req),  64'd1);
        chk("slow_addr", 64'(bus.inst_sram_addr), 64'hBFC0_0010);
        br_bus = {1'b1, 32'h8000_0200};
        tick();
        br_bus = 33'd0;
        for (int i = 0; i < 3; i++) begin
            chk("slow_addr_hold", 64'(bus.inst_sram_addr), 64'hBFC0_0010);
            chk("slow_req_hold",  64'(bus.inst_sram_req),  64'd1);
            tick();
        end
        a_dly = 0;
        wait_pc(32'h8000_0200, 20, "slow_redir_ce");
        stall = 6'b000001;
        tick(2);
        chk("slow_log_a", 64'(req_log[req_log.size() - 2]), 64'hBFC0_0010);
        chk("slow_log_b", 64'(req_log[req_log.size() - 1]), 64'h8000_0200);

        // Delay slot: branch seen while the buffer holds BFC0_0004
        rst   = 1'b1;
        stall = 6'b0;
        tick(2);
        exp_pc.push_back(32'hBFC0_0000);
        exp_pc.push_back(32'hBFC0_0004);
        exp_pc.push_back(32'h8000_0100);
        exp_pc.push_back(32'h8000_0104);
        rst = 1'b0;
        wait_pc(32'hBFC0_0004, 20, "slot_ce");
        stall  = 6'b000010;
        br_bus = {1'b1, 32'h8000_0100};
        tick();
        chk("slot_held_ce", 64'(ce),     64'd1);
        chk("slot_held_pc", 64'(bus_pc), 64'hBFC0_0004);
        br_bus = 33'd0;
        stall  = 6'b0;
        wait_pc(32'h8000_0104, 20, "redir_ce");
        stall = 6'b000001;
        tick(2);
        chk("redir_log_a", 64'(req_log[req_log.size() - 2]), 64'h8000_0100);
        chk("redir_log_b", 64'(req_log[req_log.size() - 1]), 64'h8000_0104);

        // Reset while waiting for data, with a data_ok in the same cycle
        d_dly = 5;
        stall = 6'b0;
        tick();
        chk("wait_req",  64'(bus.inst_sram_req),  64'd1);
        chk("wait_addr", 64'(bus.inst_sram_addr), 64'h8000_0108);
        tick();
        chk("wait_state_req", 64'(bus.inst_sram_req), 64'd0);
        rst    = 1'b1;
        inject = 1'b1;
        tick();
        chk("mid_rst_req",      64'(bus.inst_sram_req),  64'd0);
        chk("mid_rst_addr",     64'(bus.inst_sram_addr), 64'hBFC0_0000);
        chk("mid_rst_bus",      64'(if_to_id_bus),       64'd0);
        chk("mid_rst_inst",     64'(if_inst),            64'd0);
        chk("mid_rst_stallreq", 64'(stallreq),           64'd0);
        inject = 1'b0;
        d_dly  = 0;
        exp_pc.push_back(32'hBFC0_0000);
        rst = 1'b0;
        tick();
        chk("restart_stallreq", 64'(stallreq),           64'd1);
        chk("restart_req",      64'(bus.inst_sram_req),  64'd1);
        chk("restart_addr",     64'(bus.inst_sram_addr), 64'hBFC0_0000);
        wait_pc(32'hBFC0_0000, 20, "restart_ce");
        stall = 6'b000001;
        tick(3);

        chk("scoreboard_empty", 64'(exp_pc.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
